// File: rtl/mem_port_arbiter.sv
// Shared single-port RAM arbiter for NUM_PORTS requesters: fixed priority with
// starvation guard (ARB_MODE 0) or round-robin (ARB_MODE 1), one-cycle read return.
`timescale 1ns/1ps

module mem_port_arbiter #(
  parameter int NUM_PORTS    = 2,
  parameter int WORD_WIDTH   = 16,
  parameter int ADDR_WIDTH   = 16,
  parameter int ARB_MODE     = 0,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                             gclk,
  input  logic                             PowerOn_n,
  input  logic [NUM_PORTS-1:0]             ReqValid,
  input  logic [NUM_PORTS-1:0]             ReqWrite,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  ReqAddr,
  input  logic [NUM_PORTS*WORD_WIDTH-1:0]  ReqWData,
  output logic [NUM_PORTS-1:0]             Grant,
  output logic [NUM_PORTS-1:0]             Stall,
  output logic [NUM_PORTS-1:0]             RespValid,
  output logic [WORD_WIDTH-1:0]            RespData,
  output logic                             RamWE,
  output logic [ADDR_WIDTH-1:0]            RamAddr,
  output logic [WORD_WIDTH-1:0]            RamWData,
  input  logic [WORD_WIDTH-1:0]            RamRData
);

  localparam int IDX_W = $clog2(NUM_PORTS);
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);
  localparam logic [IDX_W-1:0] LAST_INIT = IDX_W'(NUM_PORTS - 1);

  logic [3:0]            starveCntR [NUM_PORTS];
  logic [IDX_W-1:0]      lastR;
  logic [NUM_PORTS-1:0]  rdOwnerR;
  logic [WORD_WIDTH-1:0] lastDataR;
  logic [ADDR_WIDTH-1:0] ramAddrR;

  logic [NUM_PORTS-1:0]  starvedS;
  logic [NUM_PORTS-1:0]  candS;
  logic [NUM_PORTS-1:0]  grantS;
  logic                  foundS;
  logic                  pickS;
  logic [IDX_W-1:0]      grantIdxS;
  logic [ADDR_WIDTH-1:0] addrS;
  logic [WORD_WIDTH-1:0] wdataS;

  // Grant selection; the first matching port in scan order wins.
  always_comb begin
    grantS = {NUM_PORTS{1'b0}};
    candS  = {NUM_PORTS{1'b0}};
    foundS = 1'b0;
    pickS  = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      starvedS[i] = ReqValid[i] & (starveCntR[i] == LIMIT);
    end
    if (!PowerOn_n) begin
      grantS = {NUM_PORTS{1'b0}};
    end else if (ARB_MODE == 0) begin
      candS = (|starvedS) ? starvedS : ReqValid;
      for (int i = 0; i < NUM_PORTS; i++) begin
        pickS     = ~foundS & candS[i];
        grantS[i] = pickS;
        foundS    = foundS | pickS;
      end
    end else begin
      // Ports above Last first, then wrap to the lowest-index valid port.
      for (int i = 0; i < NUM_PORTS; i++) begin
        pickS     = ~foundS & ReqValid[i] & (IDX_W'(i) > lastR);
        grantS[i] = pickS;
        foundS    = foundS | pickS;
      end
      for (int i = 0; i < NUM_PORTS; i++) begin
        pickS     = ~foundS & ReqValid[i];
        grantS[i] = grantS[i] | pickS;
        foundS    = foundS | pickS;
      end
    end
  end

  // One-hot mux of the granted request onto the RAM side.
  always_comb begin
    addrS     = {ADDR_WIDTH{1'b0}};
    wdataS    = {WORD_WIDTH{1'b0}};
    grantIdxS = {IDX_W{1'b0}};
    for (int i = 0; i < NUM_PORTS; i++) begin
      addrS     = addrS | ({ADDR_WIDTH{grantS[i]}} & ReqAddr[i*ADDR_WIDTH +: ADDR_WIDTH]);
      wdataS    = wdataS | ({WORD_WIDTH{grantS[i]}} & ReqWData[i*WORD_WIDTH +: WORD_WIDTH]);
      grantIdxS = grantIdxS | (grantS[i] ? IDX_W'(i) : {IDX_W{1'b0}});
    end
  end

  assign Grant     = grantS;
  assign Stall     = ReqValid & ~grantS;
  assign RamWE     = |(grantS & ReqWrite);
  assign RamAddr   = (|grantS) ? addrS : ramAddrR;
  assign RamWData  = wdataS;
  assign RespValid = rdOwnerR;
  assign RespData  = (|rdOwnerR) ? RamRData : lastDataR;

  // Read ownership, response hold, address hold and round-robin pointer.
  always_ff @(posedge gclk or negedge PowerOn_n) begin
    if (!PowerOn_n) begin
      rdOwnerR  <= {NUM_PORTS{1'b0}};
      lastDataR <= {WORD_WIDTH{1'b0}};
      ramAddrR  <= {ADDR_WIDTH{1'b0}};
      lastR     <= LAST_INIT;
    end else begin
      rdOwnerR <= grantS & ~ReqWrite;
      ramAddrR <= RamAddr;
      if (|rdOwnerR) begin
        lastDataR <= RamRData;
      end
      if ((ARB_MODE != 0) && (|grantS)) begin
        lastR <= grantIdxS;
      end
    end
  end

  // Per-port starvation counters; held at zero in round-robin mode.
  always_ff @(posedge gclk or negedge PowerOn_n) begin
    if (!PowerOn_n) begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        starveCntR[i] <= 4'd0;
      end
    end else begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        if ((ARB_MODE != 0) || !ReqValid[i] || grantS[i]) begin
          starveCntR[i] <= 4'd0;
        end else if (starveCntR[i] != LIMIT) begin
          starveCntR[i] <= starveCntR[i] + 4'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench: a 2-port fixed-priority arbiter and a 4-port round-robin
// arbiter, each driving a small synchronous RAM model.
`timescale 1ns/1ps

module tb_mem_port_arbiter;

  logic clk;
  logic rstN;
  int   nChecks;
  int   nFail;

  // 2-port, fixed priority, starvation limit 4
  logic [1:0]  valid0, write0, grant0, stall0, rv0;
  logic [31:0] addr0, wdata0;
  logic [15:0] rd0, ramAddr0, ramWData0, ramRData0;
  logic        we0;

  // 4-port, round-robin
  logic [3:0]  valid1, write1, grant1, stall1, rv1;
  logic [63:0] addr1, wdata1;
  logic [15:0] rd1, ramAddr1, ramWData1, ramRData1;
  logic        we1;

  logic [15:0] mem0 [256];
  logic [15:0] mem1 [256];

  mem_port_arbiter #(.NUM_PORTS(2), .WORD_WIDTH(16), .ADDR_WIDTH(16),
                     .ARB_MODE(0), .STARVE_LIMIT(4)) dut0 (
    .gclk(clk), .PowerOn_n(rstN), .ReqValid(valid0), .ReqWrite(write0),
    .ReqAddr(addr0), .ReqWData(wdata0), .Grant(grant0), .Stall(stall0),
    .RespValid(rv0), .RespData(rd0), .RamWE(we0), .RamAddr(ramAddr0),
    .RamWData(ramWData0), .RamRData(ramRData0));

  mem_port_arbiter #(.NUM_PORTS(4), .WORD_WIDTH(16), .ADDR_WIDTH(16),
                     .ARB_MODE(1), .STARVE_LIMIT(4)) dut1 (
    .gclk(clk), .PowerOn_n(rstN), .ReqValid(valid1), .ReqWrite(write1),
    .ReqAddr(addr1), .ReqWData(wdata1), .Grant(grant1), .Stall(stall1),
    .RespValid(rv1), .RespData(rd1), .RamWE(we1), .RamAddr(ramAddr1),
    .RamWData(ramWData1), .RamRData(ramRData1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] ramInit(input logic [7:0] a);
    case (a)
      8'd3:    return 16'h0333;
      8'd4:    return 16'h0444;
      8'd5:    return 16'h00C2;
      8'd6:    return 16'h0666;
      8'd7:    return 16'h0777;
      default: return {8'hA5, a};
    endcase
  endfunction

  // RAM models: contents reload while reset is low
  always @(posedge clk) begin
    if (!rstN) for (int i = 0; i < 256; i++) mem0[i] <= ramInit(8'(i));
    else if (we0) mem0[ramAddr0[7:0]] <= ramWData0;
    ramRData0 <= mem0[ramAddr0[7:0]];
  end

  always @(posedge clk) begin
    if (!rstN) for (int j = 0; j < 256; j++) mem1[j] <= ramInit(8'(j));
    else if (we1) mem1[ramAddr1[7:0]] <= ramWData1;
    ramRData1 <= mem1[ramAddr1[7:0]];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [1:0]  v, w;
    logic [15:0] a0, a1, wd0, wd1;
    logic [1:0]  eg, es, erv;
    logic [15:0] erd;
    logic        ewe;
    logic [15:0] eaddr, ewd;
  } vec_t;

  function automatic vec_t mk(input logic [1:0] v, w, input logic [15:0] a0, a1, wd0, wd1,
                              input logic [1:0] eg, es, erv, input logic [15:0] erd,
                              input logic ewe, input logic [15:0] eaddr, ewd);
    vec_t r;
    r.v = v; r.w = w; r.a0 = a0; r.a1 = a1; r.wd0 = wd0; r.wd1 = wd1;
    r.eg = eg; r.es = es; r.erv = erv; r.erd = erd; r.ewe = ewe;
    r.eaddr = eaddr; r.ewd = ewd;
    return r;
  endfunction

  localparam int NV = 21;
  vec_t tv [NV];

  int          seqG [9];
  logic [3:0]  seqV [9];
  logic [3:0]  expG;
  int          prevG;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    nChecks = 0; nFail = 0;
    rstN = 1'b0;
    valid0 = 2'b00; write0 = 2'b00; addr0 = 32'd0; wdata0 = 32'd0;
    valid1 = 4'b0000; write1 = 4'b0000; wdata1 = 64'd0;
    addr1 = {16'd13, 16'd12, 16'd11, 16'd10};

    // read, idle, write/read, back-to-back reads, starvation pattern
    tv[0]  = mk(2'b01, 2'b00, 16'd5, 16'd0, 16'h0, 16'h0,    2'b01, 2'b00, 2'b00, 16'h0000, 1'b0, 16'd5, 16'h0);
    tv[1]  = mk(2'b00, 2'b00, 16'd0, 16'd0, 16'h0, 16'h0,    2'b00, 2'b00, 2'b01, 16'h00C2, 1'b0, 16'd5, 16'h0);
    tv[2]  = mk(2'b00, 2'b00, 16'd0, 16'd0, 16'h0, 16'h0,    2'b00, 2'b00, 2'b00, 16'h00C2, 1'b0, 16'd5, 16'h0);
    tv[3]  = mk(2'b10, 2'b10, 16'd0, 16'd8, 16'h0, 16'h1886, 2'b10, 2'b00, 2'b00, 16'h00C2, 1'b1, 16'd8, 16'h1886);
    tv[4]  = mk(2'b01, 2'b00, 16'd8, 16'd0, 16'h0, 16'h0,    2'b01, 2'b00, 2'b00, 16'h00C2, 1'b0, 16'd8, 16'h0);
    tv[5]  = mk(2'b00, 2'b00, 16'd0, 16'd0, 16'h0, 16'h0,    2'b00, 2'b00, 2'b01, 16'h1886, 1'b0, 16'd8, 16'h0);
    tv[6]  = mk(2'b10, 2'b00, 16'd0, 16'd3, 16'h0, 16'h0,    2'b10, 2'b00, 2'b00, 16'h1886, 1'b0, 16'd3, 16'h0);
    tv[7]  = mk(2'b01, 2'b00, 16'd4, 16'd0, 16'h0, 16'h0,    2'b01, 2'b00, 2'b10, 16'h0333, 1'b0, 16'd4, 16'h0);
    tv[8]  = mk(2'b00, 2'b00, 16'd0, 16'd0, 16'h0, 16'h0,    2'b00, 2'b00, 2'b01, 16'h0444, 1'b0, 16'd4, 16'h0);
    tv[9]  = mk(2'b00, 2'b00, 16'd0, 16'd0, 16'h0, 16'h0,    2'b00, 2'b00, 2'b00, 16'h0444, 1'b0, 16'd4, 16'h0);
    tv[10] = mk(2'b11, 2'b00, 16'd6, 16'd7, 16'h0, 16'h0,    2'b01, 2'b10, 2'b00, 16'h0444, 1'b0, 16'd6, 16'h0);
    tv[11] = mk(2'b11, 2'b00, 16'd6, 16'd7, 16'h0, 16'h0,    2'b01, 2'b10, 2'b01, 16'h0666, 1'b0, 16'd6, 16'h0);
    tv[12] = mk(2'b11, 2'b00, 16'd6, 16'd7, 16'h0, 16'h0,    2'b01, 2'b10, 2'b01, 16'h0666, 1'b0, 16'd6, 16'h0);
    tv[13] = mk(2'b11, 2'b00, 16'd6, 16'd7, 16'h0, 16'h0,    2'b01, 2'b10, 2'b01, 16'h0666, 1'b0, 16'd6, 16'h0);
    tv[14] = mk(2'b11, 2'b00, 16'd6, 16'd7, 16'h0, 16'h0,    2'b10, 2'b01, 2'b01, 16'h0666, 1'b0, 16'd7, 16'h0);
    tv[15] = mk(2'b11, 2'b00, 16'd6, 16'd7, 16'h0, 16'h0,    2'b01, 2'b10, 2'b10, 16'h0777, 1'b0, 16'd6, 16'h0);
    tv[16] = mk(2'b11, 2'b00, 16'd6, 16'd7, 16'h0, 16'h0,    2'b01, 2'b10, 2'b01, 16'h0666, 1'b0, 16'd6, 16'h0);
    tv[17] = mk(2'b11, 2'b00, 16'd6, 16'd7, 16'h0, 16'h0,    2'b01, 2'b10, 2'b01, 16'h0666, 1'b0, 16'd6, 16'h0);
    tv[18] = mk(2'b11, 2'b00, 16'd6, 16'd7, 16'h0, 16'h0,    2'b01, 2'b10, 2'b01, 16'h0666, 1'b0, 16'd6, 16'h0);
    tv[19] = mk(2'b11, 2'b00, 16'd6, 16'd7, 16'h0, 16'h0,    2'b10, 2'b01, 2'b01, 16'h0666, 1'b0, 16'd7, 16'h0);
    tv[20] = mk(2'b00, 2'b00, 16'd0, 16'd0, 16'h0, 16'h0,    2'b00, 2'b00, 2'b10, 16'h0777, 1'b0, 16'd7, 16'h0);

    seqG = '{0, 1, 2, 3, 0, -1, 1, 3, 0};
    seqV = '{4'b1111, 4'b1111, 4'b1111, 4'b1111, 4'b1111, 4'b0000, 4'b1011, 4'b1011, 4'b1011};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_grant", 32'(grant0), 32'h0);
    chk("rst_resp_valid", 32'(rv0), 32'h0);
    chk("rst_resp_data", 32'(rd0), 32'h0);
    chk("rst_ram_addr", 32'(ramAddr0), 32'h0);
    chk("rst_ram_we", 32'(we0), 32'h0);
    @(negedge clk);
    rstN = 1'b1;

    // Reset asserted while a read response is outstanding
    @(posedge clk); #1;
    valid0 = 2'b01; addr0 = {16'd0, 16'd4};
    @(posedge clk); #1;
    valid0 = 2'b00;
    chk("pre_rst_resp_valid", 32'(rv0), 32'h1);
    chk("pre_rst_resp_data", 32'(rd0), 32'h0444);
    rstN = 1'b0;
    #1;
    chk("midrst_resp_valid", 32'(rv0), 32'h0);
    chk("midrst_resp_data", 32'(rd0), 32'h0);
    chk("midrst_ram_addr", 32'(ramAddr0), 32'h0);
    valid0 = 2'b01; write0 = 2'b01; addr0 = {16'd0, 16'd9}; wdata0 = {16'd0, 16'hFFFF};
    #1;
    chk("midrst_grant_forced", 32'(grant0), 32'h0);
    chk("midrst_we_forced", 32'(we0), 32'h0);
    chk("midrst_wdata_forced", 32'(ramWData0), 32'h0);
    @(negedge clk);
    valid0 = 2'b00; write0 = 2'b00; addr0 = 32'd0; wdata0 = 32'd0;
    @(negedge clk);
    rstN = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #4;
      chk("post_rst_no_resp", 32'(rv0), 32'h0);
    end

    // Table-driven fixed-priority vectors
    for (int k = 0; k < NV; k++) begin
      @(posedge clk); #1;
      valid0 = tv[k].v; write0 = tv[k].w;
      addr0  = {tv[k].a1, tv[k].a0};
      wdata0 = {tv[k].wd1, tv[k].wd0};
      #3;
      chk($sformatf("v%0d_grant", k), 32'(grant0), 32'(tv[k].eg));
      chk($sformatf("v%0d_stall", k), 32'(stall0), 32'(tv[k].es));
      chk($sformatf("v%0d_resp_valid", k), 32'(rv0), 32'(tv[k].erv));
      chk($sformatf("v%0d_resp_data", k), 32'(rd0), 32'(tv[k].erd));
      chk($sformatf("v%0d_ram_we", k), 32'(we0), 32'(tv[k].ewe));
      chk($sformatf("v%0d_ram_addr", k), 32'(ramAddr0), 32'(tv[k].eaddr));
      chk($sformatf("v%0d_ram_wdata", k), 32'(ramWData0), 32'(tv[k].ewd));
    end
    @(posedge clk); #1;
    valid0 = 2'b00;

    // Round-robin: full rotation and wrap, idle, then port 2 drops out
    prevG = -1;
    for (int k = 0; k < 9; k++) begin
      @(posedge clk); #1;
      valid1 = seqV[k];
      #3;
      expG = (seqG[k] < 0) ? 4'b0000 : 4'(4'b0001 << seqG[k]);
      chk($sformatf("rr%0d_grant", k), 32'(grant1), 32'(expG));
      chk($sformatf("rr%0d_stall", k), 32'(stall1), 32'(seqV[k] & ~expG));
      chk($sformatf("rr%0d_resp_valid", k), 32'(rv1),
          (prevG < 0) ? 32'h0 : 32'(4'(4'b0001 << prevG)));
      if (prevG >= 0) begin
        chk($sformatf("rr%0d_resp_data", k), 32'(rd1), 32'(ramInit(8'(10 + prevG))));
      end
      prevG = seqG[k];
    end
    @(posedge clk); #1;
    valid1 = 4'b0000;
    #3;
    chk("rr_final_resp_valid", 32'(rv1), 32'(4'(4'b0001 << prevG)));
    chk("rr_final_resp_data", 32'(rd1), 32'(ramInit(8'(10 + prevG))));

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
